xor_bus_initiator: RTL and testbench

//  Host-side initiator for the 3-bit-address XOR register interface. Accepts operand pairs on a

---
 rtl/xor_if_pkg.sv | 28 ++
 rtl/xor_bus_initiator.sv | 213 +++++++++++++++++++++
 tb/tb_xor_bus_initiator.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_if_pkg.sv
// Shared definitions for the XOR register interface: bus address map and
// the initiator's transaction state encoding.
package xor_if_pkg;

  localparam logic [2:0] ADDR_A_ST   = 3'd0;
  localparam logic [2:0] ADDR_B_ST   = 3'd1;
  localparam logic [2:0] ADDR_Y_ST   = 3'd2;
  localparam logic [2:0] ADDR_Y_DATA = 3'd3;
  localparam logic [2:0] ADDR_A_WR   = 3'd4;
  localparam logic [2:0] ADDR_B_WR   = 3'd5;

  // P* issue a read strobe, W* wait for its response, WR* perform a write.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_PA   = 4'd1,
    ST_WA   = 4'd2,
    ST_WRA  = 4'd3,
    ST_PB   = 4'd4,
    ST_WB   = 4'd5,
    ST_WRB  = 4'd6,
    ST_PY   = 4'd7,
    ST_WY   = 4'd8,
    ST_RD   = 4'd9,
    ST_WD   = 4'd10,
    ST_OUT  = 4'd11
  } xor_state_e;

endpackage

// File: rtl/xor_bus_initiator.sv
// Host-side initiator for the XOR register slave: writes an operand pair after
// polling for space, polls for the result, reads it back and returns it on a stream.
//
// Handshakes: op and res streams transfer on a rising CLK edge where valid and
// ready are both high; res_valid/res_data/res_err hold steady until res_ready.
// Bus reads are a one-cycle read_en strobe answered by read_rdy exactly one cycle
// later; only one read is ever outstanding. write_en is only raised while write_rdy=1.
module xor_bus_initiator
  import xor_if_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 1,
  parameter int POLL_MAX = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              op_valid,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              op_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  input  logic              res_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  input  logic              write_rdy,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy,
  output xor_state_e        state_dbg
);

  localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

  xor_state_e        state;
  xor_state_e        state_nxt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_err_q;
  logic [PCW-1:0]    poll_cnt;

  logic              latch_op;
  logic              latch_res;
  logic              poll_clr;
  logic              poll_inc;
  logic              abort;
  logic              status_ok;
  logic              poll_last;

  assign status_ok = read_data[0];
  assign poll_last = (poll_cnt == POLL_LAST);
  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      poll_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (latch_op) begin
        a_q        <= op_a;
        b_q        <= op_b;
        res_data_q <= '0;
        res_err_q  <= 1'b0;
      end
      if (abort) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end else if (latch_res) begin
        res_data_q <= read_data;
      end
      if (poll_clr) begin
        poll_cnt <= '0;
      end else if (poll_inc) begin
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    latch_op      = 1'b0;
    latch_res     = 1'b0;
    poll_clr      = 1'b0;
    poll_inc      = 1'b0;
    abort         = 1'b0;
    op_ready      = 1'b0;
    res_valid     = 1'b0;
    res_data      = '0;
    res_err       = 1'b0;
    write_en      = 1'b0;
    write_address = '0;
    write_data    = '0;
    read_en       = 1'b0;
    read_address  = '0;

    unique case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          latch_op  = 1'b1;
          poll_clr  = 1'b1;
          state_nxt = ST_PA;
        end
      end
      ST_PA: begin
        read_en      = 1'b1;
        read_address = ADDR_W'(ADDR_A_ST);
        state_nxt    = ST_WA;
      end
      ST_WA: begin
        if (read_rdy) begin
          if (status_ok) begin
            state_nxt = ST_WRA;
          end else if (poll_last) begin
            abort     = 1'b1;
            state_nxt = ST_OUT;
          end else begin
            poll_inc  = 1'b1;
            state_nxt = ST_PA;
          end
        end
      end
      ST_WRA: begin
        write_address = ADDR_W'(ADDR_A_WR);
        write_data    = a_q;
        if (write_rdy) begin
          write_en  = 1'b1;
          poll_clr  = 1'b1;
          state_nxt = ST_PB;
        end
      end
      ST_PB: begin
        read_en      = 1'b1;
        read_address = ADDR_W'(ADDR_B_ST);
        state_nxt    = ST_WB;
      end
      ST_WB: begin
        if (read_rdy) begin
          if (status_ok) begin
            state_nxt = ST_WRB;
          end else if (poll_last) begin
            abort     = 1'b1;
            state_nxt = ST_OUT;
          end else begin
            poll_inc  = 1'b1;
            state_nxt = ST_PB;
          end
        end
      end
      ST_WRB: begin
        write_address = ADDR_W'(ADDR_B_WR);
        write_data    = b_q;
        if (write_rdy) begin
          write_en  = 1'b1;
          poll_clr  = 1'b1;
          state_nxt = ST_PY;
        end
      end
      ST_PY: begin
        read_en      = 1'b1;
        read_address = ADDR_W'(ADDR_Y_ST);
        state_nxt    = ST_WY;
      end
      ST_WY: begin
        if (read_rdy) begin
          if (status_ok) begin
            state_nxt = ST_RD;
          end else if (poll_last) begin
            abort     = 1'b1;
            state_nxt = ST_OUT;
          end else begin
            poll_inc  = 1'b1;
            state_nxt = ST_PY;
          end
        end
      end
      ST_RD: begin
        read_en      = 1'b1;
        read_address = ADDR_W'(ADDR_Y_DATA);
        state_nxt    = ST_WD;
      end
      ST_WD: begin
        if (read_rdy) begin
          latch_res = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        res_valid = 1'b1;
        res_data  = res_data_q;
        res_err   = res_err_q;
        // Returning to IDLE raises op_ready on the same edge that completes the result.
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xor_bus_initiator.sv
// Self-checking bench for xor_bus_initiator: a behavioural XOR slave with
// programmable status polls, and a result scoreboard fed when operands are accepted.
module tb_xor_bus_initiator;
  import xor_if_pkg::*;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 1;
  localparam int POLL_MAX = 16;
  localparam int BUDGET   = 400;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              op_valid = 1'b0;
  logic [DATA_W-1:0] op_a = '0;
  logic [DATA_W-1:0] op_b = '0;
  logic              op_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              res_ready = 1'b0;
  logic              write_en;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_rdy = 1'b1;
  logic              read_en;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] read_data = '0;
  logic              read_rdy = 1'b0;
  xor_state_e        state_dbg;

  xor_bus_initiator #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .POLL_MAX(POLL_MAX)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .op_valid     (op_valid),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_ready     (op_ready),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_err      (res_err),
    .res_ready    (res_ready),
    .write_en     (write_en),
    .write_address(write_address),
    .write_data   (write_data),
    .write_rdy    (write_rdy),
    .read_en      (read_en),
    .read_address (read_address),
    .read_data    (read_data),
    .read_rdy     (read_rdy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W:0]        exp_q[$];      // {err, data}
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$]; // {addr, data}
  logic [ADDR_W+DATA_W-1:0] wr_log[$];
  int acc_cyc;
  int first_valid_cyc;

  // ---------------- slave model ----------------
  int rd_cnt[8];
  int wr_cnt;
  int wr4_cnt;
  int rd0_at_wr4;
  int a_zero, b_zero, y_zero;
  bit y_stuck, hold_y;
  logic [DATA_W-1:0] slv_a = '0, slv_b = '0;
  bit pend = 1'b0;
  logic [DATA_W-1:0] pend_data = '0;

  always @(negedge CLK) begin
    logic [DATA_W-1:0] d;
    if (!RST_N) begin
      pend = 1'b0;
    end else begin
      if (write_en) begin
        wr_log.push_back({write_address, write_data});
        wr_cnt++;
        if (write_address == 3'd4) begin
          slv_a = write_data;
          wr4_cnt++;
          rd0_at_wr4 = rd_cnt[0];
        end else if (write_address == 3'd5) begin
          slv_b = write_data;
        end
      end
      if (read_en) begin
        rd_cnt[read_address]++;
        d = '0;
        case (read_address)
          3'd0: if (a_zero > 0) a_zero--; else d = 1'b1;
          3'd1: if (b_zero > 0) b_zero--; else d = 1'b1;
          3'd2: if (y_stuck) d = 1'b0; else if (y_zero > 0) y_zero--; else d = 1'b1;
          3'd3: d = slv_a ^ slv_b;
          default: d = '0;
        endcase
        if (!(hold_y && read_address == 3'd2)) begin
          pend      = 1'b1;
          pend_data = d;
        end
      end
    end
  end

  // Response appears in the cycle after the accepted strobe, for one cycle.
  always @(posedge CLK) begin
    #1;
    read_rdy  = pend;
    read_data = pend ? pend_data : '0;
    pend      = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    for (int i = 0; i < 8; i++) rd_cnt[i] = 0;
    wr_cnt = 0; wr4_cnt = 0; rd0_at_wr4 = -1;
    a_zero = 0; b_zero = 0; y_zero = 0;
    y_stuck = 1'b0; hold_y = 1'b0;
    exp_wr_q.delete();
    wr_log.delete();
  endtask

  task automatic send_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input bit will_abort);
    int n = 0;
    @(negedge CLK);
    op_valid = 1'b1; op_a = a; op_b = b;
    while (!op_ready && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    if (!op_ready) begin
      checks++; errors++;
      $display("FAIL send_op: op_ready=%0b never rose, required 1", op_ready);
      op_valid = 1'b0;
    end else begin
      exp_q.push_back(will_abort ? {1'b1, {DATA_W{1'b0}}} : {1'b0, a ^ b});
      exp_wr_q.push_back({3'd4, a});
      exp_wr_q.push_back({3'd5, b});
      @(posedge CLK);
      #1;
      acc_cyc  = cyc;
      op_valid = 1'b0;
    end
  endtask

  // Waits for res_valid, optionally holds res_ready low for some cycles checking
  // stability, then completes the handshake.
  task automatic collect_result(input string name, input int hold_cycles, input bit keep_ready);
    int n = 0;
    logic [DATA_W:0] exp;
    @(negedge CLK);
    while (!res_valid && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL %s: res_valid=%0b after %0d cycles, required 1", name, res_valid, n);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got {err,data}=%b with no expected result queued", name, {res_err, res_data});
    end else begin
      first_valid_cyc = cyc;
      exp = exp_q.pop_front();
      if ({res_err, res_data} !== exp)
        begin errors++; $display("FAIL %s: {err,data}=%b, required %b", name, {res_err, res_data}, exp); end
      for (int k = 0; k < hold_cycles; k++) begin
        res_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if ({res_valid, res_err, res_data} !== {1'b1, exp}) begin
          errors++;
          $display("FAIL %s_hold: {valid,err,data}=%b, required %b", name,
                   {res_valid, res_err, res_data}, {1'b1, exp});
        end
      end
      res_ready = 1'b1;
      @(posedge CLK);
      #1;
      if (!keep_ready) res_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({op_ready, res_valid, res_data, res_err, write_en, write_address, write_data,
         read_en, read_address} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b rv=%0b rd=%0b re=%0b we=%0b wa=%0d ren=%0b ra=%0d, required rdy=1 rest 0",
               op_ready, res_valid, res_data, res_err, write_en, write_address, read_en, read_address);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: state=%0d, required %0d", state_dbg, ST_IDLE);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_single();
    logic [ADDR_W+DATA_W-1:0] e, g;
    clear_stats();
    send_op(1'b1, 1'b0, 1'b0);
    collect_result("single_result", 2, 1'b0);
    // Both the accepting cycle and the first res_valid cycle are counted.
    checks++;
    if (first_valid_cyc - acc_cyc + 2 != 12) begin
      errors++;
      $display("FAIL single_latency: %0d cycles, required 12", first_valid_cyc - acc_cyc + 2);
    end
    @(negedge CLK);
    checks++;
    if ({op_ready, res_valid} !== 2'b10) begin
      errors++; $display("FAIL single_return_idle: {op_ready,res_valid}=%b, required 10", {op_ready, res_valid});
    end
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      g = (wr_log.size() > 0) ? wr_log.pop_front() : '1;
      checks++;
      if (g !== e) begin errors++; $display("FAIL single_write: {addr,data}=%b, required %b", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W+DATA_W-1:0] e, g;
    logic [DATA_W-1:0] pa[3];
    logic [DATA_W-1:0] pb[3];
    clear_stats();
    pa[0] = 1'b0; pb[0] = 1'b0;
    pa[1] = 1'b1; pb[1] = 1'b1;
    pa[2] = 1'b0; pb[2] = 1'b1;
    res_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) send_op(pa[i], pb[i], 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) collect_result("b2b_result", 0, 1'b1);
      end
    join
    res_ready = 1'b0;
    checks++;
    if ({rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3], wr_cnt} != {32'd3, 32'd3, 32'd3, 32'd3, 32'd6}) begin
      errors++;
      $display("FAIL b2b_bus_count: reads %0d/%0d/%0d/%0d writes %0d, required 3/3/3/3 writes 6",
               rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3], wr_cnt);
    end
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      g = (wr_log.size() > 0) ? wr_log.pop_front() : '1;
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_write: {addr,data}=%b, required %b", g, e); end
    end
  endtask

  task automatic test_poll_a();
    clear_stats();
    a_zero = 3;
    send_op(1'b0, 1'b1, 1'b0);
    collect_result("poll_a_result", 1, 1'b0);
    checks++;
    if (rd0_at_wr4 != 4 || rd_cnt[0] != 4) begin
      errors++;
      $display("FAIL poll_a_reads: addr0 reads before write4=%0d total=%0d, required 4", rd0_at_wr4, rd_cnt[0]);
    end
  endtask

  task automatic test_poll_y_abort();
    clear_stats();
    y_stuck = 1'b1;
    send_op(1'b1, 1'b0, 1'b1);
    collect_result("poll_y_abort_result", 1, 1'b0);
    checks++;
    if (rd_cnt[2] != POLL_MAX) begin
      errors++; $display("FAIL poll_y_reads: addr2 reads=%0d, required %0d", rd_cnt[2], POLL_MAX);
    end
    checks++;
    if (rd_cnt[3] != 0) begin
      errors++; $display("FAIL poll_y_no_data_read: addr3 reads=%0d, required 0", rd_cnt[3]);
    end
  endtask

  task automatic test_write_stall();
    int n = 0;
    int bad = 0;
    clear_stats();
    write_rdy = 1'b0;
    send_op(1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    while (!(read_en && read_address == 3'd0) && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (write_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || wr_cnt != 0) begin
      errors++; $display("FAIL stall_strobe_low: write_en high %0d cycles, writes=%0d, required 0", bad, wr_cnt);
    end
    @(posedge CLK);
    #1;
    write_rdy = 1'b1;
    collect_result("stall_result", 0, 1'b0);
    checks++;
    if (wr4_cnt != 1 || wr_cnt != 2) begin
      errors++; $display("FAIL stall_single_write: writes to 4=%0d total=%0d, required 1 and 2", wr4_cnt, wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    clear_stats();
    hold_y = 1'b1;
    res_ready = 1'b0;
    send_op(1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    while (!(read_en && read_address == 3'd2) && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({op_ready, res_valid, res_data, res_err, write_en, read_en, read_address} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdy=%0b rv=%0b rd=%0b re=%0b we=%0b ren=%0b ra=%0d, required rdy=1 rest 0",
               op_ready, res_valid, res_data, res_err, write_en, read_en, read_address);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (read_en || write_en || !op_ready) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_mid_quiet: %0d cycles with strobes during reset, required 0", bad);
    end
    RST_N = 1'b1;
    hold_y = 1'b0;
    exp_q.delete();
    clear_stats();
    send_op(1'b0, 1'b1, 1'b0);
    collect_result("reset_mid_recover", 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rd_cnt[i] = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_poll_a();
    test_poll_y_abort();
    test_write_stall();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
